regfile_multiport: RTL and testbench

//  Parametrised register file for the single-cycle / next-gen pipelined datapath: NUM_RD async read ports, 1 sync write port.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/regfile_multiport.sv | 76 +++++++
 tb/tb_regfile_multiport.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Preset contents are defined by init_val().
package regfile_pkg;
   typedef enum logic {INIT, RUN} rf_state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam logic [31:0] DEF_INIT_STRIDE = 32'h1000_0011;

   // Preset value of entry idx; the caller keeps the low DATA_W bits (mod 2**DATA_W).
   function automatic logic [63:0] init_val(input logic [63:0] idx, input logic [63:0] stride);
      return idx * stride;
   endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with NUM_RD lookup ports.
// A set and a clear of the same register on one edge leaves the bit set.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     clrn,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_addr,
   input  logic                     clr_en,
   input  logic [ADDR_W-1:0]        clr_addr,
   input  logic [NUM_RD*ADDR_W-1:0] look_addr,
   output logic [NUM_RD-1:0]        look_pend
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] pend, set_vec, clr_vec;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (set_en) set_vec[set_addr] = 1'b1;
      if (clr_en) clr_vec[clr_addr] = 1'b1;
   end

   // Bit 0 is masked so register 0 never reads as pending.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) pend <= '0;
      else       pend <= ((pend & ~clr_vec) | set_vec) & ~DEPTH'(1);
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_look
      assign look_pend[k] = pend[look_addr[k*ADDR_W +: ADDR_W]];
   end
endmodule

// File: rtl/regfile_multiport.sv
// Register file: NUM_RD async read ports, one sync write port, preset sequencer, pending scoreboard.
// Optional write-through forwarding to the read ports under REGFILE_BYPASS_EN.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int                DATA_W      = DEF_DATA_W,
   parameter int                ADDR_W      = DEF_ADDR_W,
   parameter int                NUM_RD      = 2,
   parameter logic [DATA_W-1:0] INIT_STRIDE = DATA_W'(DEF_INIT_STRIDE)
) (
   input  logic                     clk,
   input  logic                     clrn,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pend,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   output logic                     init_busy
);
   localparam int DEPTH = 2**ADDR_W;

   rf_state_t         state;
   logic [ADDR_W-1:0] cnt;
   logic              run;
   logic [NUM_RD-1:0] sb_pend;
   logic [DATA_W-1:0] mem [DEPTH];

   assign run = (state == RUN);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state     <= INIT;
         cnt       <= '0;
         init_busy <= 1'b1;
      end else if (state == INIT) begin
         cnt <= cnt + 1'b1;
         if (cnt == '1) begin
            state     <= RUN;
            init_busy <= 1'b0;
         end
      end
   end

   // Array has no reset; the sequencer rewrites every entry after each clrn release.
   always_ff @(posedge clk) begin
      if (!run)                          mem[cnt]     <= DATA_W'(init_val(64'(cnt), 64'(INIT_STRIDE)));
      else if (wr_en && wr_addr != '0)   mem[wr_addr] <= wr_data;
   end

   regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_sb (
      .clk       (clk),
      .clrn      (clrn),
      .set_en    (run && rsv_en && rsv_addr != '0),
      .set_addr  (rsv_addr),
      .clr_en    (run && wr_en),
      .clr_addr  (wr_addr),
      .look_addr (rd_addr),
      .look_pend (sb_pend)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              hit;
      assign a = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      assign hit = run && wr_en && (wr_addr != '0) && (wr_addr == a);
`else
      assign hit = 1'b0;
`endif
      assign rd_data[k*DATA_W +: DATA_W] = (!run || a == '0) ? '0 : (hit ? wr_data : mem[a]);
      assign rd_pend[k] = run && !hit && sb_pend[k];
   end
endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport (2 read ports, 32x32); honours REGFILE_BYPASS_EN.
module tb_regfile_multiport;
   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic [9:0]  rd_addr = '0;
   logic [63:0] rd_data;
   logic [1:0]  rd_pend;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        rsv_en = 1'b0;
   logic [4:0]  rsv_addr = '0;
   logic        init_busy;

   int total = 0;
   int bad = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile_multiport dut (
      .clk(clk), .clrn(clrn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pend(rd_pend),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;  logic [4:0] wa; logic [31:0] wd;
      logic        re;  logic [4:0] ra;
      logic [4:0]  a0;  logic [4:0] a1;
      logic [31:0] d0;  logic [31:0] d1;
      logic        p0;  logic       p1;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] d0; logic [31:0] d1;
      logic        p0; logic        p1;
   } exp_t;

   vec_t vt [19];
   exp_t sbq [$];

   function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic re, logic [4:0] ra,
                               logic [4:0] a0, logic [4:0] a1, logic [31:0] d0, logic [31:0] d1,
                               logic p0, logic p1);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
      v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.p0 = p0; v.p1 = p1;
      return v;
   endfunction

   task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input int i);
      exp_t e;
      @(negedge clk);
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rsv_en = vt[i].re; rsv_addr = vt[i].ra;
      rd_addr = {vt[i].a1, vt[i].a0};
      sbq.push_back('{idx: i, d0: vt[i].d0, d1: vt[i].d1, p0: vt[i].p0, p1: vt[i].p1});
      #2;
      e = sbq.pop_front();
      check("rd_data0", e.idx, rd_data[31:0],  e.d0);
      check("rd_data1", e.idx, rd_data[63:32], e.d1);
      check("rd_pend0", e.idx, 32'(rd_pend[0]), 32'(e.p0));
      check("rd_pend1", e.idx, 32'(rd_pend[1]), 32'(e.p1));
      check("busy_run", e.idx, 32'(init_busy), 32'd0);
   endtask

   // Release clrn and count the cycles init_busy stays high; optionally hammer wr/rsv on entry 3 meanwhile.
   task automatic release_and_wait(input bit poke);
      int n = 0;
      @(negedge clk);
      clrn = 1'b1;
      wr_en = poke; wr_addr = 5'd3; wr_data = 32'hBAD0_BAD0;
      rsv_en = poke; rsv_addr = 5'd3;
      rd_addr = {5'd3, 5'd3};
      while (init_busy && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (n == 4) begin
            check("init_rd_data", n, 32'(rd_data[31:0] | rd_data[63:32]), 32'd0);
            check("init_rd_pend", n, 32'(rd_pend), 32'd0);
         end
      end
      check("init_len", 0, n, 32'd32);
      @(negedge clk);
      wr_en = 1'b0; rsv_en = 1'b0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
   endtask

   initial begin
      vt[0]  = mk(0, 0, 0,            0, 0,  3,  0, 32'h3000_0033, 0, 0, 0);
      vt[1]  = mk(1, 5, 32'hDEAD_BEEF, 0, 0,  5,  1, BYP ? 32'hDEAD_BEEF : 32'h5000_0055, 32'h1000_0011, 0, 0);
      vt[2]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0,  5,  0, 32'hDEAD_BEEF, 0, 0, 0);
      vt[3]  = mk(0, 0, 0,            1, 7,  7,  7, 32'h7000_0077, 32'h7000_0077, 0, 0);
      vt[4]  = mk(0, 0, 0,            0, 0,  7,  6, 32'h7000_0077, 32'h6000_0066, 1, 0);
      vt[5]  = mk(1, 7, 32'h77,       0, 0,  7,  7, BYP ? 32'h77 : 32'h7000_0077, BYP ? 32'h77 : 32'h7000_0077, !BYP, !BYP);
      vt[6]  = mk(0, 0, 0,            0, 0,  7,  7, 32'h77, 32'h77, 0, 0);
      vt[7]  = mk(1, 7, 32'hAB,       1, 7,  8,  8, 32'h8000_0088, 32'h8000_0088, 0, 0);
      vt[8]  = mk(0, 0, 0,            0, 0,  7,  8, 32'hAB, 32'h8000_0088, 1, 0);
      vt[9]  = mk(1, 9, 32'h1234_5678, 0, 0,  0,  9, 0, BYP ? 32'h1234_5678 : 32'h9000_0099, 0, 0);
      vt[10] = mk(0, 0, 0,            0, 0,  9,  9, 32'h1234_5678, 32'h1234_5678, 0, 0);
      vt[11] = mk(0, 0, 0,            1, 0,  0,  0, 0, 0, 0, 0);
      vt[12] = mk(0, 0, 0,            0, 0,  0, 31, 0, 32'hF000_020F, 0, 0);
      vt[13] = mk(1, 7, 32'hCD,       0, 0,  7,  7, BYP ? 32'hCD : 32'hAB, BYP ? 32'hCD : 32'hAB, !BYP, !BYP);
      vt[14] = mk(0, 0, 0,            0, 0,  7,  0, 32'hCD, 0, 0, 0);
      vt[15] = mk(1, 5, 32'h5555_0000, 1, 12, 12, 5, 32'hC000_00CC, BYP ? 32'h5555_0000 : 32'hDEAD_BEEF, 0, 0);
      vt[16] = mk(0, 0, 0,            0, 0, 12,  5, 32'hC000_00CC, 32'h5555_0000, 1, 0);
      vt[17] = mk(0, 0, 0,            0, 0,  5, 12, 32'h5000_0055, 32'hC000_00CC, 0, 0);
      vt[18] = mk(0, 0, 0,            0, 0,  7,  9, 32'h7000_0077, 32'h9000_0099, 0, 0);

      #12;
      check("rst_busy", 0, 32'(init_busy), 32'd1);
      check("rst_rd_data", 0, rd_data[31:0], 32'd0);

      // First init with writes/reservations to entry 3 that must be dropped (vt[0] reads it back).
      release_and_wait(1'b1);
      for (int i = 0; i <= 16; i++) apply(i);

      // clrn mid-RUN: reservation on 12 and write to 5 must both disappear.
      @(negedge clk);
      clrn = 1'b0;
      #2;
      check("midrst_busy", 0, 32'(init_busy), 32'd1);
      check("midrst_pend", 0, 32'(rd_pend), 32'd0);
      check("midrst_data", 0, 32'(rd_data[31:0] | rd_data[63:32]), 32'd0);
      release_and_wait(1'b0);
      for (int i = 17; i <= 18; i++) apply(i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
